debouncer_multi: RTL and testbench



---
 rtl/debouncer_pkg.sv | 13 +
 rtl/debouncer_ch.sv | 85 ++++++++
 rtl/debouncer_multi.sv | 57 +++++
 tb/tb_debouncer_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - shared constants and width helper for the debouncer family
package debouncer_pkg;

    localparam int DEF_N_MAX       = 50;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CLK_HZ      = 50_000_000;

    // Width of a counter that must hold values 0..x inclusive.
    function automatic int cnt_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/debouncer_ch.sv
// rtl/debouncer_ch.sv - one debounce channel: synchroniser, filter, edge and long-press pulses
module debouncer_ch
    import debouncer_pkg::*;
#(
    parameter int N_MAX       = DEF_N_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LONG_MAX    = 0
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int CW = cnt_width(N_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [CW-1:0]          cnt;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Metastability chain; the oldest sample sits in the MSB.
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
        end
    end

    // Stability filter: accept a new level only after N_MAX consecutive mismatching cycles.
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_lvl != dout) begin
                if (cnt == CW'(N_MAX - 1)) begin
                    cnt  <= '0;
                    dout <= sync_lvl;
                    rise <= sync_lvl;
                    fall <= ~sync_lvl;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    generate
        if (LONG_MAX > 0) begin : g_long
            localparam int LW = cnt_width(LONG_MAX);
            logic [LW-1:0] lcnt;

            // Count cycles of dout high; saturate at LONG_MAX so the pulse fires only once per press.
            always_ff @(posedge clk) begin
                if (rst_a_p) begin
                    lcnt       <= '0;
                    long_press <= 1'b0;
                end else begin
                    long_press <= 1'b0;
                    if (!dout) begin
                        lcnt <= '0;
                    end else if (lcnt < LW'(LONG_MAX)) begin
                        lcnt       <= lcnt + LW'(1);
                        long_press <= (lcnt == LW'(LONG_MAX - 1));
                    end
                end
            end
        end else begin : g_no_long
            assign long_press = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - N_CH independent debounce channels with a shared change flag
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int N_MAX       = DEF_N_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LONG_MAX    = 0
) (
    input  logic            clk,
    input  logic            rst_a_p,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press,
    output logic            any_change
);

    generate
        if (N_CH < 1) begin : g_bad_n_ch
            $error("debouncer_multi: N_CH must be >= 1");
        end
        if (N_MAX < 1) begin : g_bad_n_max
            $error("debouncer_multi: N_MAX must be >= 1");
        end
        if (SYNC_STAGES < 1) begin : g_bad_sync
            $error("debouncer_multi: SYNC_STAGES must be >= 1");
        end
        if (LONG_MAX < 0) begin : g_bad_long
            $error("debouncer_multi: LONG_MAX must be >= 0");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            debouncer_ch #(
                .N_MAX       (N_MAX),
                .SYNC_STAGES (SYNC_STAGES),
                .LONG_MAX    (LONG_MAX)
            ) u_ch (
                .clk        (clk),
                .rst_a_p    (rst_a_p),
                .din        (din[i]),
                .dout       (dout[i]),
                .rise       (rise[i]),
                .fall       (fall[i]),
                .long_press (long_press[i])
            );
        end
    endgenerate

    // Pulses are registered per channel, so this OR lines up with them.
    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - scoreboard bench for debouncer_multi against a sample-history model
module tb_debouncer_multi;

    localparam int NC   = 4;
    localparam int NM   = 50;
    localparam int SS   = 2;
    localparam int LM   = 200;
    localparam int MAXE = 20000;

    logic          clk = 1'b0;
    logic          rst_a_p;
    logic [NC-1:0] din;
    logic [NC-1:0] dout, rise, fall, long_press;
    logic          any_change;

    always #10 clk = ~clk;

    debouncer_multi #(
        .N_CH        (NC),
        .N_MAX       (NM),
        .SYNC_STAGES (SS),
        .LONG_MAX    (LM)
    ) dut (
        .clk        (clk),
        .rst_a_p    (rst_a_p),
        .din        (din),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press),
        .any_change (any_change)
    );

    typedef struct packed {
        logic [NC-1:0] dout;
        logic [NC-1:0] rise;
        logic [NC-1:0] fall;
        logic [NC-1:0] lp;
        logic          ac;
    } obs_t;

    obs_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: every din sample is kept; the synchronised level seen at
    // edge k is simply the sample taken SS edges earlier (zero if reset intervened).
    logic [NC-1:0] samp [0:MAXE-1];
    int  edge_no  = 0;
    int  last_rst = 0;
    int  m_run       [NC];
    bit  m_dout      [NC];
    int  m_rise_edge [NC];

    always @(posedge clk) begin
        obs_t e;
        bit   s;
        bit   old;
        e = '0;
        edge_no++;
        if (edge_no < MAXE) samp[edge_no] = din;
        if (rst_a_p) begin
            last_rst = edge_no;
            for (int c = 0; c < NC; c++) begin
                m_run[c]  = 0;
                m_dout[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                s   = (edge_no - SS >= 1 && edge_no - SS > last_rst) ? samp[edge_no - SS][c] : 1'b0;
                old = m_dout[c];
                if (old && (edge_no - m_rise_edge[c] == LM)) e.lp[c] = 1'b1;
                if (s != old) begin
                    m_run[c]++;
                    if (m_run[c] == NM) begin
                        m_run[c]  = 0;
                        m_dout[c] = s;
                        if (s) begin
                            e.rise[c]      = 1'b1;
                            m_rise_edge[c] = edge_no;
                        end else begin
                            e.fall[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                e.dout[c] = m_dout[c];
            end
        end
        e.ac = |(e.rise | e.fall);
        exp_q.push_back(e);
    end

    // Monitor: compare every cycle's outputs away from the active edge and log pulse events.
    int rise_cnt [NC];
    int fall_cnt [NC];
    int lp_cnt   [NC];
    int rise_edge[NC];
    int lp_edge  [NC];
    int all_rise_seen = 0;

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dout, rise, fall, long_press, any_change};
            check($sformatf("cycle_outputs@edge%0d", edge_no), int'(a), int'(e));
            for (int c = 0; c < NC; c++) begin
                if (rise[c])       begin rise_cnt[c]++; rise_edge[c] = edge_no; end
                if (fall[c])       fall_cnt[c]++;
                if (long_press[c]) begin lp_cnt[c]++; lp_edge[c] = edge_no; end
            end
            if (rise == {NC{1'b1}} && any_change) all_rise_seen++;
        end
    end

    int e1;
    int base;
    int hold [NC];

    initial begin
        for (int c = 0; c < NC; c++) begin
            rise_cnt[c] = 0; fall_cnt[c] = 0; lp_cnt[c] = 0;
            rise_edge[c] = 0; lp_edge[c] = 0; m_rise_edge[c] = 0;
            m_run[c] = 0; m_dout[c] = 1'b0;
        end
        din     = '0;
        rst_a_p = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_dout", int'(dout), 0);
        check("reset_pulses", int'({rise, fall, long_press, any_change}), 0);
        rst_a_p = 1'b0;

        // Idle with din low.
        repeat (60) @(negedge clk);
        check("idle_dout", int'(dout), 0);

        // Sub-cycle bounce on channel 0, then hold high.
        #5  din[0] = 1'b1;
        #30 din[0] = 1'b0;
        #20 din[0] = 1'b1;
        #10 din[0] = 1'b0;
        #40 din[0] = 1'b1;
        e1 = edge_no + 1;
        repeat (70) @(negedge clk);
        check("bounce_rise_latency", rise_edge[0] - e1 + 1, SS + NM);
        check("bounce_rise_count", rise_cnt[0], 1);
        check("bounce_other_channels", int'(dout[3:1]), 0);

        // 49 cycles high on channel 1 is one short of acceptance.
        din[1] = 1'b1;
        repeat (NM - 1) @(negedge clk);
        din[1] = 1'b0;
        repeat (70) @(negedge clk);
        check("short_pulse_no_rise", rise_cnt[1], 0);

        // Long press on channel 2, then release, then a press released too early.
        din[2] = 1'b1;
        repeat (SS + NM + LM + 60) @(negedge clk);
        check("long_press_once", lp_cnt[2], 1);
        check("long_press_offset", lp_edge[2] - rise_edge[2], LM);
        din[2] = 1'b0;
        repeat (70) @(negedge clk);
        check("long_release_fall", fall_cnt[2], 1);
        din[2] = 1'b1;
        repeat (SS + NM + 100) @(negedge clk);
        din[2] = 1'b0;
        repeat (80) @(negedge clk);
        check("early_release_no_long", lp_cnt[2], 1);
        check("early_release_fall", fall_cnt[2], 2);

        // All channels pressed on the same edge.
        din = '0;
        repeat (70) @(negedge clk);
        din = {NC{1'b1}};
        repeat (70) @(negedge clk);
        check("simultaneous_rise", all_rise_seen, 1);
        check("simultaneous_dout", int'(dout), (1 << NC) - 1);

        // Reset in the middle of a pending rise with din[0] held.
        din = '0;
        repeat (70) @(negedge clk);
        base = rise_cnt[0];
        din[0] = 1'b1;
        repeat (SS + 30) @(negedge clk);
        rst_a_p = 1'b1;
        @(negedge clk);
        check("midcount_reset_outputs", int'({dout, rise, fall, long_press, any_change}), 0);
        rst_a_p = 1'b0;
        e1 = edge_no + 1;
        repeat (70) @(negedge clk);
        check("post_reset_rise_count", rise_cnt[0] - base, 1);
        check("post_reset_rise_latency", rise_edge[0] - e1 + 1, SS + NM);

        // Random hold lengths straddling the filter threshold, occasional resets.
        for (int c = 0; c < NC; c++) hold[c] = $urandom_range(120, 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_a_p = ($urandom_range(599, 0) == 0);
            for (int c = 0; c < NC; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    din[c]  = ~din[c];
                    hold[c] = ($urandom_range(1, 0) == 1) ? $urandom_range(60, 1)
                                                          : $urandom_range(300, 40);
                end
            end
        end
        rst_a_p = 1'b0;
        din     = '0;
        repeat (300) @(negedge clk);
        check("final_dout_low", int'(dout), 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
